// File: rtl/bullet_manager.sv
// Bullet table for two tanks: allocates on fire edges, moves on frame_tick,
// retires off-screen bullets and reports hits on the opposing tank.
module bullet_manager #(
  parameter int TANK_NUM   = 2,
  parameter int ARRAY_SIZE = 8,
  parameter int IMG_SIZE   = 32,
  parameter int SPEED      = 4,
  parameter int COOLDOWN   = 15,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                                       CLK,
  input  logic                                       Reset,
  input  logic                                       frame_tick,
  input  logic                                       fire1,
  input  logic                                       fire2,
  input  logic [9:0]                                 tank1_x,
  input  logic [9:0]                                 tank1_y,
  input  logic [9:0]                                 tank2_x,
  input  logic [9:0]                                 tank2_y,
  input  logic [2:0]                                 turret1_direction,
  input  logic [2:0]                                 turret2_direction,
  output logic [TANK_NUM-1:0][ARRAY_SIZE-1:0][31:0]  bullet_array,
  output logic                                       hit1,
  output logic                                       hit2
);

  localparam logic signed [10:0] LP_S    = SPEED[10:0];
  localparam logic signed [10:0] LP_W    = SCREEN_W[10:0];
  localparam logic signed [10:0] LP_H    = SCREEN_H[10:0];
  localparam logic        [10:0] LP_IMG  = IMG_SIZE[10:0];
  localparam logic        [9:0]  LP_HALF = IMG_SIZE[10:1];
  localparam logic        [3:0]  LP_CD   = COOLDOWN[3:0];

  logic [TANK_NUM-1:0][ARRAY_SIZE-1:0][31:0] r_tbl;
  logic [TANK_NUM-1:0][ARRAY_SIZE-1:0][31:0] w_tbl_nxt;
  logic [1:0][3:0] r_cd;
  logic [1:0][3:0] w_cd_nxt;
  logic [1:0]      r_fire_prev;
  logic            r_hit1;
  logic            r_hit2;
  logic [1:0]      w_fire;
  logic [1:0]      w_accept;
  logic [1:0]      w_free_ok;
  logic [1:0]      w_row_hit;
  logic [1:0][2:0] w_free_idx;
  logic [1:0][2:0] w_dir;
  logic [1:0][9:0] w_tx;
  logic [1:0][9:0] w_ty;
  logic [1:0][9:0] w_ox;
  logic [1:0][9:0] w_oy;
  logic [32:0]     w_mv;

  assign w_fire = {fire2, fire1};
  assign w_dir  = {turret2_direction, turret1_direction};
  assign w_tx   = {tank2_x, tank1_x};
  assign w_ty   = {tank2_y, tank1_y};
  assign w_ox   = {tank1_x, tank2_x};
  assign w_oy   = {tank1_y, tank2_y};

  // Returns {hit, new_entry}; an off-screen or hitting bullet comes back as an all-zero entry.
  function automatic logic [32:0] f_move(input logic [31:0] e, input logic [9:0] ox,
                                         input logic [9:0] oy);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic        [10:0] ux;
    logic        [10:0] uy;
    logic        [32:0] res;
    case (e[3:1])
      3'd0:    begin dx = 11'sd0; dy = -LP_S;  end
      3'd1:    begin dx = LP_S;   dy = -LP_S;  end
      3'd2:    begin dx = LP_S;   dy = 11'sd0; end
      3'd3:    begin dx = LP_S;   dy = LP_S;   end
      3'd4:    begin dx = 11'sd0; dy = LP_S;   end
      3'd5:    begin dx = -LP_S;  dy = LP_S;   end
      3'd6:    begin dx = -LP_S;  dy = 11'sd0; end
      3'd7:    begin dx = -LP_S;  dy = -LP_S;  end
      default: begin dx = 11'sd0; dy = 11'sd0; end
    endcase
    nx = $signed({1'b0, e[18:9]}) + dx;
    ny = $signed({1'b0, e[28:19]}) + dy;
    ux = $unsigned(nx);
    uy = $unsigned(ny);
    if ((nx < 11'sd0) || (ny < 11'sd0) || (nx >= LP_W) || (ny >= LP_H)) begin
      res = 33'd0;
    end else if ((ux >= {1'b0, ox}) && (ux < ({1'b0, ox} + LP_IMG)) &&
                 (uy >= {1'b0, oy}) && (uy < ({1'b0, oy} + LP_IMG))) begin
      res = {1'b1, 32'd0};
    end else begin
      res = {1'b0, 3'd0, uy[9:0], ux[9:0], e[8:0]};
    end
    return res;
  endfunction

  // Lowest free slot per row, judged on the registered (pre-tick) valid bits.
  always_comb begin
    w_free_ok  = 2'b00;
    w_free_idx = {3'd0, 3'd0};
    for (int t = 0; t < 2; t++) begin
      for (int s = ARRAY_SIZE - 1; s >= 0; s--) begin
        w_free_idx[t] = r_tbl[t][s][0] ? w_free_idx[t] : 3'(s);
        w_free_ok[t]  = w_free_ok[t] | ~r_tbl[t][s][0];
      end
    end
  end

  assign w_accept = w_fire & ~r_fire_prev & {(r_cd[1] == 4'd0), (r_cd[0] == 4'd0)} & w_free_ok;

  // Next table: spawn wins on its slot, otherwise valid slots move on a tick.
  always_comb begin
    w_tbl_nxt = r_tbl;
    w_row_hit = 2'b00;
    w_mv      = 33'd0;
    for (int t = 0; t < 2; t++) begin
      for (int s = 0; s < ARRAY_SIZE; s++) begin
        if (w_accept[t] && (w_free_idx[t] == 3'(s))) begin
          w_tbl_nxt[t][s] = {3'd0, w_ty[t] + LP_HALF, w_tx[t] + LP_HALF, 5'd0, w_dir[t], 1'b1};
        end else if (frame_tick && r_tbl[t][s][0]) begin
          w_mv            = f_move(r_tbl[t][s], w_ox[t], w_oy[t]);
          w_tbl_nxt[t][s] = w_mv[31:0];
          w_row_hit[t]    = w_row_hit[t] | w_mv[32];
        end else begin
          w_tbl_nxt[t][s] = r_tbl[t][s];
        end
      end
    end
  end

  // Cooldown: a successful shot reloads, otherwise each tick counts down to zero.
  always_comb begin
    w_cd_nxt = r_cd;
    for (int t = 0; t < 2; t++) begin
      if (w_accept[t]) begin
        w_cd_nxt[t] = LP_CD;
      end else if (frame_tick && (r_cd[t] != 4'd0)) begin
        w_cd_nxt[t] = r_cd[t] - 4'd1;
      end else begin
        w_cd_nxt[t] = r_cd[t];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_tbl       <= '0;
      r_cd        <= {4'd0, 4'd0};
      r_fire_prev <= 2'b00;
      r_hit1      <= 1'b0;
      r_hit2      <= 1'b0;
    end else begin
      r_tbl       <= w_tbl_nxt;
      r_cd        <= w_cd_nxt;
      r_fire_prev <= w_fire;
      r_hit1      <= w_row_hit[1];
      r_hit2      <= w_row_hit[0];
    end
  end

  assign bullet_array = r_tbl;
  assign hit1         = r_hit1;
  assign hit2         = r_hit2;

endmodule

// File: tb/tb_bullet_manager.sv
// Self-checking bench for bullet_manager: directed spec scenarios plus a
// randomized run against a behavioural model of the bullet rules.
module tb_bullet_manager;

  logic                   CLK = 1'b0;
  logic                   Reset;
  logic                   frame_tick;
  logic                   fire1, fire2;
  logic [9:0]             tank1_x, tank1_y, tank2_x, tank2_y;
  logic [2:0]             turret1_direction, turret2_direction;
  logic [1:0][7:0][31:0]  bullet_array;
  logic                   hit1, hit2;

  int checks   = 0;
  int failures = 0;

  bit mv[2][8];
  int mdir[2][8];
  int mx[2][8];
  int my[2][8];
  int mcd[2];
  bit mprev[2];
  bit mh[2];
  int DXT[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int DYT[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  bullet_manager dut (
    .CLK(CLK), .Reset(Reset), .frame_tick(frame_tick), .fire1(fire1), .fire2(fire2),
    .tank1_x(tank1_x), .tank1_y(tank1_y), .tank2_x(tank2_x), .tank2_y(tank2_y),
    .turret1_direction(turret1_direction), .turret2_direction(turret2_direction),
    .bullet_array(bullet_array), .hit1(hit1), .hit2(hit2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] pack(int x, int y, int d);
    return {3'd0, 10'(y), 10'(x), 5'd0, 3'(d), 1'b1};
  endfunction

  function automatic logic [31:0] mentry(int t, int s);
    return mv[t][s] ? pack(mx[t][s], my[t][s], mdir[t][s]) : 32'd0;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      for (int s = 0; s < 8; s++) begin
        mv[t][s] = 1'b0; mdir[t][s] = 0; mx[t][s] = 0; my[t][s] = 0;
      end
      mcd[t] = 0; mprev[t] = 1'b0; mh[t] = 1'b0;
    end
  endtask

  task automatic model_update();
    int tx[2]; int ty[2]; int tur[2]; bit f[2]; bit pv[2][8];
    int nx; int ny; int o; bit found;
    tx[0] = tank1_x; ty[0] = tank1_y; tx[1] = tank2_x; ty[1] = tank2_y;
    tur[0] = turret1_direction; tur[1] = turret2_direction;
    f[0] = fire1; f[1] = fire2;
    pv = mv;
    mh[0] = 1'b0; mh[1] = 1'b0;
    if (frame_tick) begin
      for (int t = 0; t < 2; t++) begin
        for (int s = 0; s < 8; s++) begin
          if (mv[t][s]) begin
            nx = mx[t][s] + 4 * DXT[mdir[t][s]];
            ny = my[t][s] + 4 * DYT[mdir[t][s]];
            o  = 1 - t;
            if (nx < 0 || nx >= 640 || ny < 0 || ny >= 480) mv[t][s] = 1'b0;
            else if (nx >= tx[o] && nx < tx[o] + 32 && ny >= ty[o] && ny < ty[o] + 32) begin
              mv[t][s] = 1'b0; mh[o] = 1'b1;
            end else begin
              mx[t][s] = nx; my[t][s] = ny;
            end
          end
        end
      end
    end
    for (int t = 0; t < 2; t++) begin
      found = 1'b0;
      if (f[t] && !mprev[t] && mcd[t] == 0) begin
        for (int s = 0; s < 8; s++) begin
          if (!found && !pv[t][s]) begin
            found = 1'b1; mv[t][s] = 1'b1; mdir[t][s] = tur[t];
            mx[t][s] = tx[t] + 16; my[t][s] = ty[t] + 16;
          end
        end
      end
      if (found) mcd[t] = 15;
      else if (frame_tick && mcd[t] > 0) mcd[t] = mcd[t] - 1;
      mprev[t] = f[t];
    end
  endtask

  task automatic step();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(int n);
    frame_tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; frame_tick = 1'b0; fire1 = 1'b0; fire2 = 1'b0;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic place(int x1, int y1, int d1, int x2, int y2, int d2);
    tank1_x = 10'(x1); tank1_y = 10'(y1); turret1_direction = 3'(d1);
    tank2_x = 10'(x2); tank2_y = 10'(y2); turret2_direction = 3'(d2);
  endtask

  task automatic test_reset();
    place(0, 0, 0, 0, 0, 0);
    Reset = 1'b1; frame_tick = 1'b0; fire1 = 1'b0; fire2 = 1'b0;
    #7;
    checks++;
    if (bullet_array !== '0 || hit1 !== 1'b0 || hit2 !== 1'b0) begin
      failures++;
      $display("FAIL reset: table=%h hit1=%b hit2=%b, expected all zero", bullet_array, hit1, hit2);
    end
    do_reset();
  endtask

  task automatic test_fire_move();
    do_reset();
    place(100, 200, 2, 500, 400, 0);
    fire1 = 1'b1; fire2 = 1'b1;
    step();
    checks++;
    if (bullet_array[0][0] !== pack(116, 216, 2) || bullet_array[1][0] !== pack(516, 416, 0)) begin
      failures++;
      $display("FAIL spawn: t1=%h t2=%h expected %h %h", bullet_array[0][0], bullet_array[1][0],
               pack(116, 216, 2), pack(516, 416, 0));
    end
    fire1 = 1'b0; fire2 = 1'b0;
    ticks(3);
    checks++;
    if (bullet_array[0][0] !== pack(128, 216, 2) || bullet_array[1][0] !== pack(516, 404, 0)) begin
      failures++;
      $display("FAIL move3: t1=%h t2=%h expected %h %h", bullet_array[0][0], bullet_array[1][0],
               pack(128, 216, 2), pack(516, 404, 0));
    end
    fire1 = 1'b1;
    step();
    checks++;
    if (bullet_array[0][1] !== 32'd0 || bullet_array[0][0] !== pack(128, 216, 2)) begin
      failures++;
      $display("FAIL cooldown_block: slot1=%h slot0=%h expected 0 and %h", bullet_array[0][1],
               bullet_array[0][0], pack(128, 216, 2));
    end
    fire1 = 1'b0;
    step();
  endtask

  task automatic test_row_full();
    do_reset();
    place(608, 100, 6, 0, 400, 0);
    for (int k = 0; k < 8; k++) begin
      fire1 = 1'b1;
      step();
      checks++;
      if (bullet_array[0][k] !== pack(624, 116, 6)) begin
        failures++;
        $display("FAIL fill_slot%0d: got %h expected %h", k, bullet_array[0][k], pack(624, 116, 6));
      end
      fire1 = 1'b0;
      ticks(15);
    end
    fire1 = 1'b1;
    step();
    checks++;
    if (bullet_array[0][0] !== pack(144, 116, 6) || bullet_array[0][7] !== pack(564, 116, 6)) begin
      failures++;
      $display("FAIL row_full: slot0=%h slot7=%h expected %h %h", bullet_array[0][0],
               bullet_array[0][7], pack(144, 116, 6), pack(564, 116, 6));
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (bullet_array[0][s] !== mentry(0, s)) begin
        failures++;
        $display("FAIL row_full_model s%0d: got %h expected %h", s, bullet_array[0][s], mentry(0, s));
      end
    end
    fire1 = 1'b0;
    step();
  endtask

  task automatic test_oob();
    do_reset();
    place(60, 100, 6, 400, 400, 0);
    fire1 = 1'b1;
    step();
    fire1 = 1'b0;
    ticks(19);
    checks++;
    if (bullet_array[0][0] !== pack(0, 116, 6)) begin
      failures++;
      $display("FAIL left_edge_x0: got %h expected %h", bullet_array[0][0], pack(0, 116, 6));
    end
    fire1 = 1'b1; frame_tick = 1'b1;
    step();
    fire1 = 1'b0; frame_tick = 1'b0;
    checks++;
    if (bullet_array[0][0] !== 32'd0 || bullet_array[0][1] !== pack(76, 116, 6) ||
        hit1 !== 1'b0 || hit2 !== 1'b0) begin
      failures++;
      $display("FAIL left_exit: slot0=%h slot1=%h hit=%b%b expected 0 %h 00", bullet_array[0][0],
               bullet_array[0][1], hit1, hit2, pack(76, 116, 6));
    end
    ticks(15);
    fire1 = 1'b1;
    step();
    fire1 = 1'b0;
    checks++;
    if (bullet_array[0][0] !== pack(76, 116, 6) || bullet_array[0][1] !== pack(16, 116, 6)) begin
      failures++;
      $display("FAIL slot_reuse: slot0=%h slot1=%h expected %h %h", bullet_array[0][0],
               bullet_array[0][1], pack(76, 116, 6), pack(16, 116, 6));
    end
    do_reset();
    place(608, 100, 2, 0, 400, 0);
    fire1 = 1'b1;
    step();
    fire1 = 1'b0;
    ticks(3);
    checks++;
    if (bullet_array[0][0] !== pack(636, 116, 2)) begin
      failures++;
      $display("FAIL right_edge_636: got %h expected %h", bullet_array[0][0], pack(636, 116, 2));
    end
    ticks(1);
    checks++;
    if (bullet_array[0][0] !== 32'd0 || hit1 !== 1'b0 || hit2 !== 1'b0) begin
      failures++;
      $display("FAIL right_exit: got %h hit=%b%b expected 0 00", bullet_array[0][0], hit1, hit2);
    end
  endtask

  task automatic test_hit();
    do_reset();
    place(110, 200, 2, 130, 200, 0);
    fire1 = 1'b1;
    step();
    fire1 = 1'b0;
    checks++;
    if (bullet_array[0][0] !== pack(126, 216, 2) || hit2 !== 1'b0) begin
      failures++;
      $display("FAIL hit_spawn: got %h hit2=%b expected %h 0", bullet_array[0][0], hit2, pack(126, 216, 2));
    end
    ticks(1);
    checks++;
    if (bullet_array[0][0] !== 32'd0 || hit2 !== 1'b1 || hit1 !== 1'b0) begin
      failures++;
      $display("FAIL hit2: entry=%h hit1=%b hit2=%b expected 0 0 1", bullet_array[0][0], hit1, hit2);
    end
    step();
    checks++;
    if (hit2 !== 1'b0) begin
      failures++;
      $display("FAIL hit2_pulse: hit2=%b expected 0", hit2);
    end
    do_reset();
    place(150, 200, 0, 200, 200, 6);
    fire2 = 1'b1;
    step();
    fire2 = 1'b0;
    ticks(8);
    checks++;
    if (bullet_array[1][0] !== pack(184, 216, 6) || hit1 !== 1'b0) begin
      failures++;
      $display("FAIL hit1_approach: got %h hit1=%b expected %h 0", bullet_array[1][0], hit1, pack(184, 216, 6));
    end
    ticks(1);
    checks++;
    if (bullet_array[1][0] !== 32'd0 || hit1 !== 1'b1 || hit2 !== 1'b0) begin
      failures++;
      $display("FAIL hit1: entry=%h hit1=%b hit2=%b expected 0 1 0", bullet_array[1][0], hit1, hit2);
    end
  endtask

  task automatic test_fire_tick_reset();
    do_reset();
    place(100, 200, 2, 500, 400, 0);
    fire1 = 1'b1;
    step();
    fire1 = 1'b0;
    ticks(15);
    fire1 = 1'b1; frame_tick = 1'b1;
    step();
    fire1 = 1'b0; frame_tick = 1'b0;
    checks++;
    if (bullet_array[0][0] !== pack(180, 216, 2) || bullet_array[0][1] !== pack(116, 216, 2)) begin
      failures++;
      $display("FAIL fire_with_tick: slot0=%h slot1=%h expected %h %h", bullet_array[0][0],
               bullet_array[0][1], pack(180, 216, 2), pack(116, 216, 2));
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (bullet_array !== '0 || hit1 !== 1'b0 || hit2 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: table=%h hit=%b%b expected zero", bullet_array, hit1, hit2);
    end
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [1:0][7:0][31:0] exp_tbl;
    int bx;
    int by;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c % 40 == 0) begin
        bx = $urandom_range(0, 300);
        by = $urandom_range(0, 440);
        if ($urandom_range(0, 1) == 0)
          place(bx, by, 0, bx + $urandom_range(40, 300), by + $urandom_range(0, 10) - 5 < 0 ? 0 : by, 0);
        else
          place(by > 300 ? 300 : by, bx, 0, by > 300 ? 300 : by, bx + $urandom_range(40, 140), 0);
      end
      turret1_direction = 3'($urandom_range(0, 7));
      turret2_direction = 3'($urandom_range(0, 7));
      fire1 = ($urandom_range(0, 2) == 0);
      fire2 = ($urandom_range(0, 2) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      step();
      for (int t = 0; t < 2; t++)
        for (int s = 0; s < 8; s++)
          exp_tbl[t][s] = mentry(t, s);
      checks++;
      if (bullet_array !== exp_tbl) begin
        failures++;
        $display("FAIL rand_table c%0d: got %h expected %h", c, bullet_array, exp_tbl);
      end
      checks++;
      if (hit1 !== mh[0] || hit2 !== mh[1]) begin
        failures++;
        $display("FAIL rand_hits c%0d: got %b%b expected %b%b", c, hit1, hit2, mh[0], mh[1]);
      end
    end
    fire1 = 1'b0; fire2 = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fire_move();
    test_row_full();
    test_oob();
    test_hit();
    test_fire_tick_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
